// File: rtl/gpio_apb_multi.sv
// APB GPIO peripheral: OUT/IN ports, hex 7-segment digits with blanking, wait states, slave error.
// Define GPIO_APB_IRQ_EN to build in the edge-detect interrupt unit (IRQ_EN/PEND/EDGE, irq).
module gpio_apb_multi #(
    parameter int OUT_W       = 16,
    parameter int IN_W        = 16,
    parameter int NUM_SEG     = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [31:0]          in_paddr,
    input  logic                 in_psel,
    input  logic                 in_penable,
    input  logic [2:0]           in_pprot,
    input  logic                 in_pwrite,
    input  logic [31:0]          in_pwdata,
    input  logic [3:0]           in_pstrb,
    output logic                 in_pready,
    output logic [31:0]          in_prdata,
    output logic                 in_pslverr,
    output logic [OUT_W-1:0]     gpio_out,
    input  logic [IN_W-1:0]      gpio_in,
    output logic [8*NUM_SEG-1:0] gpio_seg,
    output logic                 irq
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'h03;  4'h1: hex7 = 8'h9F;  4'h2: hex7 = 8'h25;  4'h3: hex7 = 8'h0D;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h49;  4'h6: hex7 = 8'h41;  4'h7: hex7 = 8'h1F;
            4'h8: hex7 = 8'h01;  4'h9: hex7 = 8'h19;  4'hA: hex7 = 8'h11;  4'hB: hex7 = 8'hC1;
            4'hC: hex7 = 8'h63;  4'hD: hex7 = 8'h85;  4'hE: hex7 = 8'h61;  default: hex7 = 8'h71;
        endcase
    endfunction

    state_t                 state;
    logic [1:0]             wcnt;
    logic [OUT_W-1:0]       out_reg;
    logic [4*NUM_SEG-1:0]   seg_reg;
    logic [NUM_SEG-1:0]     blank_reg;
    logic [IN_W-1:0]        sync_p1, sync_p2;
    logic                   access, xfer, wr;
    logic [2:0]             idx;
    logic [31:0]            wmask, wval, rd_data;
    logic                   rd_err;
    logic                   unused_bits;

    assign unused_bits = ^{in_pprot, in_paddr[31:5], in_paddr[1:0]};
    assign access = in_psel & in_penable;
    // Zero wait states: ready straight from IDLE in the first access cycle
    assign in_pready = (WAIT_STATES == 0) ? (access && state == S_IDLE) : (state == S_READY);
    assign xfer  = access & in_pready;
    assign wr    = xfer & in_pwrite;
    assign idx   = in_paddr[4:2];
    assign wmask = strb_mask(in_pstrb);
    assign wval  = in_pwdata & wmask;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            wcnt  <= 2'd0;
        end else begin
            case (state)
                S_IDLE: if (access && WAIT_STATES != 0) begin
                    wcnt  <= 2'd1;
                    state <= (WAIT_STATES == 1) ? S_READY : S_WAIT;
                end
                S_WAIT: begin
                    if (!access)                          state <= S_IDLE;
                    else if (32'(wcnt) == WAIT_STATES - 1) state <= S_READY;
                    else                                  wcnt  <= 2'(wcnt + 2'd1);
                end
                S_READY: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_reg   <= '0;
            seg_reg   <= '0;
            blank_reg <= '1;
            sync_p1   <= '0;
            sync_p2   <= '0;
        end else begin
            sync_p1 <= gpio_in;
            sync_p2 <= sync_p1;
            if (wr && idx == 3'd0) out_reg   <= OUT_W'((32'(out_reg) & ~wmask) | wval);
            if (wr && idx == 3'd2) seg_reg   <= (4*NUM_SEG)'((32'(seg_reg) & ~wmask) | wval);
            if (wr && idx == 3'd3) blank_reg <= NUM_SEG'((32'(blank_reg) & ~wmask) | wval);
        end
    end

`ifdef GPIO_APB_IRQ_EN
    logic [IN_W-1:0] sync_p3, irq_en, irq_pend, irq_edge, edge_hit, pend_clr;

    // Stage 2 vs. stage 3 compare; polarity chosen per bit by IRQ_EDGE
    assign edge_hit = (sync_p2 & ~sync_p3 & irq_edge) | (~sync_p2 & sync_p3 & ~irq_edge);
    assign pend_clr = (wr && idx == 3'd5) ? IN_W'(wval) : '0;
    assign irq      = |(irq_pend & irq_en);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p3  <= '0;
            irq_en   <= '0;
            irq_pend <= '0;
            irq_edge <= '1;
        end else begin
            sync_p3  <= sync_p2;
            irq_pend <= (irq_pend & ~pend_clr) | edge_hit;
            if (wr && idx == 3'd4) irq_en   <= IN_W'((32'(irq_en) & ~wmask) | wval);
            if (wr && idx == 3'd6) irq_edge <= IN_W'((32'(irq_edge) & ~wmask) | wval);
        end
    end
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (idx)
            3'd0: rd_data = 32'(out_reg);
            3'd1: rd_data = 32'(sync_p2);
            3'd2: rd_data = 32'(seg_reg);
            3'd3: rd_data = 32'(blank_reg);
`ifdef GPIO_APB_IRQ_EN
            3'd4: rd_data = 32'(irq_en);
            3'd5: rd_data = 32'(irq_pend);
            3'd6: rd_data = 32'(irq_edge);
`endif
            3'd7: rd_err  = 1'b1;
            default: rd_data = '0;
        endcase
    end

    assign in_prdata  = in_pready ? rd_data : 32'd0;
    assign in_pslverr = in_pready & rd_err;
    assign gpio_out   = out_reg;

    for (genvar i = 0; i < NUM_SEG; i++) begin : g_seg
        assign gpio_seg[8*i +: 8] = blank_reg[i] ? 8'hFF : hex7(seg_reg[4*i +: 4]);
    end

endmodule
